// File: rtl/dff_asyn_rst_2_pkg.sv
// rtl/dff_asyn_rst_2_pkg.sv - shared defaults for the dff_asyn_rst_2 register slice
`timescale 1ns/100ps
package dff_asyn_rst_2_pkg;

  // Default data width and pipeline depth of the register slice.
  localparam int DEF_WIDTH = 1;
  localparam int DEF_DEPTH = 1;

  // Number of flops in the reset-release synchronizer.
  localparam int RST_SYNC_STAGES = 2;

  // Default reset value, replicated across WIDTH by the user of the package.
  localparam logic DEF_RST_BIT = 1'b0;

endpackage

// File: rtl/dff_asyn_rst_2_if.sv
// rtl/dff_asyn_rst_2_if.sv - data in/out bundle for dff_asyn_rst_2
`timescale 1ns/100ps
interface dff_asyn_rst_2_if
  import dff_asyn_rst_2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  // Producer side: drives data in, observes the registered output.
  modport master (output d, input q);

  // Register side: samples data in, drives the registered output.
  modport slave (input d, output q);

endinterface

// File: rtl/dff_asyn_rst_2_rst_sync_n.sv
// rtl/dff_asyn_rst_2_rst_sync_n.sv - async-assert, sync-deassert active-low reset synchronizer
`timescale 1ns/100ps
module rst_sync_n #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic ar_n,
  output logic rst_n
);

  logic [STAGES-1:0] sync;

  // Clear the chain immediately on assertion; shift ones in after release so
  // the downstream reset lifts only after STAGES clean rising edges.
  always_ff @(posedge clk or negedge ar_n) begin
    if (!ar_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[STAGES-2:0], 1'b1};
    end
  end

  assign rst_n = sync[STAGES-1];

endmodule

// File: rtl/dff_asyn_rst_2.sv
// rtl/dff_asyn_rst_2.sv - DEPTH-stage D register with async active-low reset (option: DFF_ASYN_RST_2_RST_SYNC_EN)
`timescale 1ns/100ps
module dff_asyn_rst_2
  import dff_asyn_rst_2_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter int               DEPTH   = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DEF_RST_BIT}}
) (
  input  logic             clk,
  input  logic             ar,
  dff_asyn_rst_2_if.slave  bus
);

  // Reset seen by every stage; assertion is always immediate.
  logic stage_rst_n;

`ifdef DFF_ASYN_RST_2_RST_SYNC_EN
  // Release is retimed to clk so an asynchronous source cannot cause a
  // partial release across stages.
  rst_sync_n #(
    .STAGES (RST_SYNC_STAGES)
  ) u_rst_sync (
    .clk   (clk),
    .ar_n  (ar),
    .rst_n (stage_rst_n)
  );
`else
  assign stage_rst_n = ar;
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] r;
    if (g == 0) begin : g_first
      // First stage captures d on every edge outside reset.
      always_ff @(posedge clk or negedge stage_rst_n) begin
        if (!stage_rst_n) begin
          r <= RST_VAL;
        end else begin
          r <= bus.d;
        end
      end
    end else begin : g_next
      // Later stages shift the previous stage; reset flushes in-flight data.
      always_ff @(posedge clk or negedge stage_rst_n) begin
        if (!stage_rst_n) begin
          r <= RST_VAL;
        end else begin
          r <= g_stage[g-1].r;
        end
      end
    end
  end

  assign bus.q = g_stage[DEPTH-1].r;

endmodule

// File: tb/tb_dff_asyn_rst_2.sv
// tb/tb_dff_asyn_rst_2.sv - directed self-checking bench for dff_asyn_rst_2
`timescale 1ns/100ps
module tb_dff_asyn_rst_2;

`ifdef DFF_ASYN_RST_2_RST_SYNC_EN
  localparam int FIRST_CAP = 3;
`else
  localparam int FIRST_CAP = 1;
`endif

  logic clk = 1'b0;
  logic ar0;
  logic ar1;
  int   tests  = 0;
  int   failed = 0;

  dff_asyn_rst_2_if #(.WIDTH(1)) if0 ();
  dff_asyn_rst_2_if #(.WIDTH(8)) if1 ();

  dff_asyn_rst_2 #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) u0 (
    .clk (clk),
    .ar  (ar0),
    .bus (if0.slave)
  );

  dff_asyn_rst_2 #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'hA5)) u1 (
    .clk (clk),
    .ar  (ar1),
    .bus (if1.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ar0 = 1'b1; if0.d = 1'b0;
    ar1 = 1'b1; if1.d = 8'h00;
    #4;
    ar0 = 1'b0; if0.d = 1'b1;
    ar1 = 1'b0;
    #0.5;
    tests++;
    if (if0.q !== 1'b0) begin
      $display("FAIL reset_async_q0: got %b want %b", if0.q, 1'b0); failed++;
    end
    tests++;
    if (if1.q !== 8'hA5) begin
      $display("FAIL reset_async_q1: got %h want %h", if1.q, 8'hA5); failed++;
    end
    #1.5;
    tests++;
    if (if0.q !== 1'b0) begin
      $display("FAIL reset_hold_edge: got %b want %b", if0.q, 1'b0); failed++;
    end
  endtask

  task automatic test_release();
    logic exp;
    #8;
    ar0 = 1'b1; if0.d = 1'b0;
    tick();
    tests++;
    if (if0.q !== 1'b0) begin
      $display("FAIL release_edge1: got %b want %b", if0.q, 1'b0); failed++;
    end
    if0.d = 1'b1;
    for (int e = 2; e <= 3; e++) begin
      tick();
      exp = (e >= FIRST_CAP) ? 1'b1 : 1'b0;
      tests++;
      if (if0.q !== exp) begin
        $display("FAIL release_edge%0d: got %b want %b", e, if0.q, exp); failed++;
      end
    end
  endtask

  task automatic test_midstream();
    #3;
    ar0 = 1'b0;
    #0.5;
    tests++;
    if (if0.q !== 1'b0) begin
      $display("FAIL mid_reset_immediate: got %b want %b", if0.q, 1'b0); failed++;
    end
    for (int i = 0; i < 4; i++) begin
      if0.d = ~if0.d;
      tick();
      tests++;
      if (if0.q !== 1'b0) begin
        $display("FAIL mid_reset_toggle%0d: got %b want %b", i, if0.q, 1'b0); failed++;
      end
    end
  endtask

  task automatic test_coincide();
    logic exp;
    if0.d = 1'b1;
    @(posedge clk);
    ar0 <= 1'b1;
    #1;
    tests++;
    if (if0.q !== 1'b0) begin
      $display("FAIL coincide_edge: got %b want %b", if0.q, 1'b0); failed++;
    end
    for (int e = 1; e <= FIRST_CAP; e++) begin
      tick();
      exp = (e >= FIRST_CAP) ? 1'b1 : 1'b0;
      tests++;
      if (if0.q !== exp) begin
        $display("FAIL coincide_next%0d: got %b want %b", e, if0.q, exp); failed++;
      end
    end
  endtask

  task automatic test_depth3();
    logic [7:0] exp;
    tests++;
    if (if1.q !== 8'hA5) begin
      $display("FAIL depth_reset: got %h want %h", if1.q, 8'hA5); failed++;
    end
    ar1 = 1'b1; if1.d = 8'h3C;
    for (int e = 1; e <= FIRST_CAP + 2; e++) begin
      tick();
      exp = (e >= FIRST_CAP + 2) ? 8'h3C : 8'hA5;
      tests++;
      if (if1.q !== exp) begin
        $display("FAIL depth_fill%0d: got %h want %h", e, if1.q, exp); failed++;
      end
    end
    if1.d = 8'h11;
    tick();
    tests++;
    if (if1.q !== 8'h3C) begin
      $display("FAIL depth_hold: got %h want %h", if1.q, 8'h3C); failed++;
    end
    #2;
    ar1 = 1'b0;
    #0.5;
    tests++;
    if (if1.q !== 8'hA5) begin
      $display("FAIL depth_mid_reset: got %h want %h", if1.q, 8'hA5); failed++;
    end
    #2;
    ar1 = 1'b1; if1.d = 8'h22;
    for (int e = 1; e <= FIRST_CAP + 2; e++) begin
      tick();
      exp = (e >= FIRST_CAP + 2) ? 8'h22 : 8'hA5;
      tests++;
      if (if1.q !== exp) begin
        $display("FAIL depth_no_stale%0d: got %h want %h", e, if1.q, exp); failed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_midstream();
    test_coincide();
    test_depth3();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
